// File: rtl/fccc_lock_rst_ctrl.sv
// PLL lock supervisor: pulses the PLL reset, debounces LOCK, detects timeout and
// lock loss, then releases NUM_RST fabric reset domains in a staggered order.
module fccc_lock_rst_ctrl #(
    parameter int NUM_RST        = 3,
    parameter int PLL_RST_CYCLES = 8,
    parameter int LOCK_FILTER    = 16,
    parameter int RELEASE_DELAY  = 4,
    parameter int TIMEOUT        = 100,
    parameter int CNT_W          = 4
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               LOCK,
    input  logic               CLR,
    output logic               PLL_ARST_N,
    output logic [NUM_RST-1:0] RST_N_OUT,
    output logic               READY,
    output logic               LOCK_FAIL,
    output logic [CNT_W-1:0]   LOSS_COUNT
);

    localparam int MAX_AB = (PLL_RST_CYCLES > TIMEOUT) ? PLL_RST_CYCLES : TIMEOUT;
    localparam int MAX_CD = (LOCK_FILTER > RELEASE_DELAY) ? LOCK_FILTER : RELEASE_DELAY;
    localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW     = $clog2(MAX_P + 1);

    localparam logic [CW-1:0]    PLL_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0]    TO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]    FLT_LAST = CW'(LOCK_FILTER - 1);
    localparam logic [CW-1:0]    REL_LAST = CW'(RELEASE_DELAY - 1);
    localparam logic [CNT_W-1:0] LOSS_MAX = '1;

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_FILTER,
        S_RELEASE,
        S_RUN
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               sync1;
    logic               lock_s;
    logic [NUM_RST-1:0] rst_shift;
    logic [CNT_W-1:0]   loss_inc;

    // LOCK comes from the PLL clock domain; two flops before any use.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1  <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            sync1  <= LOCK;
            lock_s <= sync1;
        end
    end

    // Next release pattern: one more low-order domain out of reset.
    assign rst_shift = NUM_RST'({RST_N_OUT, 1'b1});
    assign loss_inc  = (LOSS_COUNT == LOSS_MAX) ? LOSS_MAX : LOSS_COUNT + 1'b1;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= S_PLL_RST;
            cnt        <= '0;
            PLL_ARST_N <= 1'b0;
            RST_N_OUT  <= '0;
            READY      <= 1'b0;
            LOCK_FAIL  <= 1'b0;
            LOSS_COUNT <= '0;
        end else begin
            // Clear first so a coincident timeout or loss below takes precedence.
            if (CLR) begin
                LOCK_FAIL  <= 1'b0;
                LOSS_COUNT <= '0;
            end

            case (state)
                S_PLL_RST: begin
                    if (cnt == PLL_LAST) begin
                        PLL_ARST_N <= 1'b1;
                        cnt        <= '0;
                        state      <= S_WAIT_LOCK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        if (LOCK_FILTER == 1) begin
                            RST_N_OUT <= NUM_RST'(1);
                            cnt       <= '0;
                            if (NUM_RST == 1) begin
                                READY <= 1'b1;
                                state <= S_RUN;
                            end else begin
                                state <= S_RELEASE;
                            end
                        end else begin
                            cnt   <= CW'(1);
                            state <= S_FILTER;
                        end
                    end else if (cnt == TO_LAST) begin
                        LOCK_FAIL  <= 1'b1;
                        PLL_ARST_N <= 1'b0;
                        cnt        <= '0;
                        state      <= S_PLL_RST;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_FILTER: begin
                    // A dropout here is just an unstable lock, not a loss event.
                    if (!lock_s) begin
                        cnt   <= '0;
                        state <= S_WAIT_LOCK;
                    end else if (cnt == FLT_LAST) begin
                        RST_N_OUT <= NUM_RST'(1);
                        cnt       <= '0;
                        if (NUM_RST == 1) begin
                            READY <= 1'b1;
                            state <= S_RUN;
                        end else begin
                            state <= S_RELEASE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_RELEASE: begin
                    if (!lock_s) begin
                        RST_N_OUT  <= '0;
                        READY      <= 1'b0;
                        LOSS_COUNT <= CLR ? CNT_W'(1) : loss_inc;
                        cnt        <= '0;
                        state      <= S_WAIT_LOCK;
                    end else if (cnt == REL_LAST) begin
                        RST_N_OUT <= rst_shift;
                        cnt       <= '0;
                        if (&rst_shift) begin
                            READY <= 1'b1;
                            state <= S_RUN;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_RUN: begin
                    // Loss goes straight back to waiting; the PLL is not reset.
                    if (!lock_s) begin
                        RST_N_OUT  <= '0;
                        READY      <= 1'b0;
                        LOSS_COUNT <= CLR ? CNT_W'(1) : loss_inc;
                        cnt        <= '0;
                        state      <= S_WAIT_LOCK;
                    end
                end

                default: begin
                    cnt   <= '0;
                    state <= S_PLL_RST;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fccc_lock_rst_ctrl.sv
// Directed bench for fccc_lock_rst_ctrl at default parameters: power-up table plus
// hand sequences for lock loss, filter dropout, timeout, saturation and async reset.
module tb_fccc_lock_rst_ctrl;

    logic       CLK;
    logic       RESET_N;
    logic       LOCK;
    logic       CLR;
    logic       PLL_ARST_N;
    logic [2:0] RST_N_OUT;
    logic       READY;
    logic       LOCK_FAIL;
    logic [3:0] LOSS_COUNT;

    int n_pass;
    int n_total;

    fccc_lock_rst_ctrl dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .LOCK       (LOCK),
        .CLR        (CLR),
        .PLL_ARST_N (PLL_ARST_N),
        .RST_N_OUT  (RST_N_OUT),
        .READY      (READY),
        .LOCK_FAIL  (LOCK_FAIL),
        .LOSS_COUNT (LOSS_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       lock;
        logic       clr;
        int         n;
        logic       arst;
        logic [2:0] rst;
        logic       ready;
        logic       fail;
        logic [3:0] loss;
    } vec_t;

    vec_t vt [11];

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic chk5(input string tag, input logic arst, input logic [2:0] rst,
                        input logic ready, input logic fail, input logic [3:0] loss);
        check($sformatf("%s.arst", tag), int'(PLL_ARST_N), int'(arst));
        check($sformatf("%s.rst", tag), int'(RST_N_OUT), int'(rst));
        check($sformatf("%s.ready", tag), int'(READY), int'(ready));
        check($sformatf("%s.fail", tag), int'(LOCK_FAIL), int'(fail));
        check($sformatf("%s.loss", tag), int'(LOSS_COUNT), int'(loss));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Leaves RESET_N deasserted 1 time unit after an edge; the next edge is edge 1.
    task automatic do_reset(input string tag);
        @(posedge CLK);
        #1;
        RESET_N = 1'b0;
        CLR     = 1'b0;
        @(posedge CLK);
        #1;
        chk5(tag, 1'b0, 3'b000, 1'b0, 1'b0, 4'd0);
        RESET_N = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_pass  = 0;
        n_total = 0;
        RESET_N = 1'b0;
        LOCK    = 1'b0;
        CLR     = 1'b0;

        // Power-up with LOCK rising 20 cycles after reset release: lock_s at edge 22.
        vt[0]  = '{1'b0, 1'b0, 1,  1'b0, 3'b000, 1'b0, 1'b0, 4'd0};
        vt[1]  = '{1'b0, 1'b0, 6,  1'b0, 3'b000, 1'b0, 1'b0, 4'd0};
        vt[2]  = '{1'b0, 1'b0, 1,  1'b1, 3'b000, 1'b0, 1'b0, 4'd0};
        vt[3]  = '{1'b0, 1'b0, 12, 1'b1, 3'b000, 1'b0, 1'b0, 4'd0};
        vt[4]  = '{1'b1, 1'b0, 17, 1'b1, 3'b000, 1'b0, 1'b0, 4'd0};
        vt[5]  = '{1'b1, 1'b0, 1,  1'b1, 3'b001, 1'b0, 1'b0, 4'd0};
        vt[6]  = '{1'b1, 1'b0, 3,  1'b1, 3'b001, 1'b0, 1'b0, 4'd0};
        vt[7]  = '{1'b1, 1'b0, 1,  1'b1, 3'b011, 1'b0, 1'b0, 4'd0};
        vt[8]  = '{1'b1, 1'b0, 3,  1'b1, 3'b011, 1'b0, 1'b0, 4'd0};
        vt[9]  = '{1'b1, 1'b0, 1,  1'b1, 3'b111, 1'b1, 1'b0, 4'd0};
        vt[10] = '{1'b1, 1'b0, 10, 1'b1, 3'b111, 1'b1, 1'b0, 4'd0};

        do_reset("rst0");
        for (int i = 0; i < 11; i++) begin
            LOCK = vt[i].lock;
            CLR  = vt[i].clr;
            step(vt[i].n);
            chk5($sformatf("pwr[%0d]", i), vt[i].arst, vt[i].rst, vt[i].ready,
                 vt[i].fail, vt[i].loss);
        end

        // One-cycle LOCK drop in RUN (now at edge 56).
        LOCK = 1'b0;
        step(1);
        chk5("run_drop57", 1'b1, 3'b111, 1'b1, 1'b0, 4'd0);
        LOCK = 1'b1;
        step(1);
        chk5("run_drop58", 1'b1, 3'b111, 1'b1, 1'b0, 4'd0);
        step(1);
        chk5("run_loss59", 1'b1, 3'b000, 1'b0, 1'b0, 4'd1);
        step(15);
        chk5("rerel74", 1'b1, 3'b000, 1'b0, 1'b0, 4'd1);
        step(1);
        chk5("rerel75", 1'b1, 3'b001, 1'b0, 1'b0, 4'd1);
        step(8);
        chk5("rerel83", 1'b1, 3'b111, 1'b1, 1'b0, 4'd1);

        // Dropout during FILTER at count 10; lock_s re-rises at edge 37.
        LOCK = 1'b0;
        do_reset("rst1");
        step(20);
        LOCK = 1'b1;
        step(10);
        chk5("flt30", 1'b1, 3'b000, 1'b0, 1'b0, 4'd0);
        LOCK = 1'b0;
        step(5);
        chk5("flt35", 1'b1, 3'b000, 1'b0, 1'b0, 4'd0);
        LOCK = 1'b1;
        step(17);
        chk5("flt52", 1'b1, 3'b000, 1'b0, 1'b0, 4'd0);
        step(1);
        chk5("flt53", 1'b1, 3'b001, 1'b0, 1'b0, 4'd0);

        // LOCK held low: timeouts at edges 108 and 216, PLL reset 8 cycles each.
        LOCK = 1'b0;
        do_reset("rst2");
        step(107);
        chk5("to107", 1'b1, 3'b000, 1'b0, 1'b0, 4'd0);
        step(1);
        chk5("to108", 1'b0, 3'b000, 1'b0, 1'b1, 4'd0);
        step(7);
        chk5("to115", 1'b0, 3'b000, 1'b0, 1'b1, 4'd0);
        step(1);
        chk5("to116", 1'b1, 3'b000, 1'b0, 1'b1, 4'd0);
        step(83);
        CLR = 1'b1;
        step(1);
        CLR = 1'b0;
        chk5("to_clr200", 1'b1, 3'b000, 1'b0, 1'b0, 4'd0);
        step(15);
        chk5("to215", 1'b1, 3'b000, 1'b0, 1'b0, 4'd0);
        CLR = 1'b1;
        step(1);
        chk5("to216_clr", 1'b0, 3'b000, 1'b0, 1'b1, 4'd0);
        step(1);
        CLR = 1'b0;
        chk5("to217_clr", 1'b0, 3'b000, 1'b0, 1'b0, 4'd0);

        // Sixteen loss events in RELEASE, then CLR with and without a coincident loss.
        LOCK = 1'b1;
        do_reset("rst3");
        step(24);
        chk5("sat_rel24", 1'b1, 3'b001, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 16; i++) begin
            LOCK = 1'b0;
            step(1);
            LOCK = 1'b1;
            step(2);
            check($sformatf("sat_loss[%0d]", i), int'(LOSS_COUNT), (i + 1 > 15) ? 15 : i + 1);
            check($sformatf("sat_rst[%0d]", i), int'(RST_N_OUT), 0);
            step(16);
            check($sformatf("sat_rel[%0d]", i), int'(RST_N_OUT), 1);
        end
        LOCK = 1'b0;
        step(1);
        LOCK = 1'b1;
        step(1);
        CLR = 1'b1;
        step(1);
        CLR = 1'b0;
        chk5("clr_with_loss", 1'b1, 3'b000, 1'b0, 1'b0, 4'd1);
        step(16);
        chk5("sat_rel_after", 1'b1, 3'b001, 1'b0, 1'b0, 4'd1);
        CLR = 1'b1;
        step(1);
        CLR = 1'b0;
        chk5("clr_alone", 1'b1, 3'b001, 1'b0, 1'b0, 4'd0);

        // Asynchronous reset in the middle of RELEASE.
        LOCK = 1'b1;
        do_reset("rst4");
        step(29);
        chk5("mid_rel29", 1'b1, 3'b011, 1'b0, 1'b0, 4'd0);
        #2;
        RESET_N = 1'b0;
        #1;
        chk5("async_rst", 1'b0, 3'b000, 1'b0, 1'b0, 4'd0);
        step(1);
        chk5("async_rst_hold", 1'b0, 3'b000, 1'b0, 1'b0, 4'd0);
        RESET_N = 1'b1;
        step(8);
        chk5("restart8", 1'b1, 3'b000, 1'b0, 1'b0, 4'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
